// File: rtl/mc_port_arbiter_pkg.sv
// Shared definitions for the MC port arbiter: MC field widths, flush FSM
// state encoding and the requester-id width helper.
package mc_port_arbiter_pkg;

    localparam int CMD_W  = 3;
    localparam int SCMD_W = 4;
    localparam int SIZE_W = 2;
    localparam int VADR_W = 48;
    localparam int DATA_W = 64;

    typedef enum logic [1:0] {
        ST_ARB        = 2'd0,
        ST_DRAIN      = 2'd1,
        ST_FLUSH      = 2'd2,
        ST_WAIT_CMPLT = 2'd3
    } arbState_t;

    // Number of low rtnctl bits that carry the requester id.
    function automatic int idWidth(input int numReq);
        return (numReq <= 1) ? 1 : $clog2(numReq);
    endfunction

endpackage

// File: rtl/mc_port_arbiter_if.sv
// Bundle of requester-side and MC-side signals for the MC port arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mc_port_arbiter_if
    import mc_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int RTNCTL_WIDTH = 32
);
    localparam int IDW  = idWidth(NUM_REQ);
    localparam int TAGW = RTNCTL_WIDTH - IDW;

    logic [NUM_REQ-1:0]        req_vld;
    logic [NUM_REQ-1:0]        req_rdy;
    logic [NUM_REQ*CMD_W-1:0]  req_cmd;
    logic [NUM_REQ*SCMD_W-1:0] req_scmd;
    logic [NUM_REQ*SIZE_W-1:0] req_size;
    logic [NUM_REQ*VADR_W-1:0] req_vadr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ*TAGW-1:0]   req_tag;

    logic                      mc_rq_vld;
    logic [CMD_W-1:0]          mc_rq_cmd;
    logic [SCMD_W-1:0]         mc_rq_scmd;
    logic [SIZE_W-1:0]         mc_rq_size;
    logic [VADR_W-1:0]         mc_rq_vadr;
    logic [DATA_W-1:0]         mc_rq_data;
    logic [RTNCTL_WIDTH-1:0]   mc_rq_rtnctl;
    logic                      mc_rq_stall;

    logic                      mc_rs_vld;
    logic [CMD_W-1:0]          mc_rs_cmd;
    logic [SCMD_W-1:0]         mc_rs_scmd;
    logic [DATA_W-1:0]         mc_rs_data;
    logic [RTNCTL_WIDTH-1:0]   mc_rs_rtnctl;
    logic                      mc_rs_stall;

    logic [NUM_REQ-1:0]        rsp_vld;
    logic [CMD_W-1:0]          rsp_cmd;
    logic [SCMD_W-1:0]         rsp_scmd;
    logic [DATA_W-1:0]         rsp_data;
    logic [TAGW-1:0]           rsp_tag;
    logic [NUM_REQ-1:0]        rsp_stall;

    logic [NUM_REQ-1:0]        flush_req;
    logic                      flush_done;
    logic                      mc_rq_flush;
    logic                      mc_rs_flush_cmplt;

    modport slave (
        input  req_vld, req_cmd, req_scmd, req_size, req_vadr, req_data, req_tag,
        output req_rdy,
        output mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_size, mc_rq_vadr, mc_rq_data, mc_rq_rtnctl,
        input  mc_rq_stall,
        input  mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_data, mc_rs_rtnctl,
        output mc_rs_stall,
        output rsp_vld, rsp_cmd, rsp_scmd, rsp_data, rsp_tag,
        input  rsp_stall,
        input  flush_req, mc_rs_flush_cmplt,
        output flush_done, mc_rq_flush
    );

    modport master (
        output req_vld, req_cmd, req_scmd, req_size, req_vadr, req_data, req_tag,
        input  req_rdy,
        input  mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_size, mc_rq_vadr, mc_rq_data, mc_rq_rtnctl,
        output mc_rq_stall,
        output mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_data, mc_rs_rtnctl,
        input  mc_rs_stall,
        input  rsp_vld, rsp_cmd, rsp_scmd, rsp_data, rsp_tag,
        output rsp_stall,
        output flush_req, mc_rs_flush_cmplt,
        input  flush_done, mc_rq_flush
    );

endinterface

// File: rtl/mc_port_arbiter_rr.sv
// Round-robin selector: the search starts one past the last granted index,
// and the pointer only moves when the caller actually takes the grant.
module rr_arbiter
    import mc_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = idWidth(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_adv,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDW-1:0]     o_grantId,
    output logic               o_any
);

    logic [IDW-1:0] r_lastGrant;
    logic [IDW-1:0] w_idx;

    // Scan from lastGrant+1 upward; NUM_REQ is a power of two so the id wraps for free.
    always_comb begin
        o_grant   = '0;
        o_grantId = '0;
        o_any     = 1'b0;
        w_idx     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = r_lastGrant + IDW'(k);
            if (!o_any && i_req[w_idx]) begin
                o_any          = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_grantId      = w_idx;
            end
        end
    end

    // Pointer resets to the top index so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lastGrant <= IDW'(NUM_REQ - 1);
        end else if (i_adv) begin
            r_lastGrant <= o_grantId;
        end
    end

endmodule

// File: rtl/mc_port_arbiter.sv
// Multi-requester front end for one MC port: round-robin request mux into a
// single output register, combinational response routing by rtnctl id, and a
// drain/flush/wait-complete sequence for write flushes.
module mc_port_arbiter
    import mc_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int RTNCTL_WIDTH = 32
) (
    input  logic               clk,
    input  logic               i_reset_n,
    mc_port_arbiter_if.slave   bus
);

    localparam int IDW  = idWidth(NUM_REQ);
    localparam int TAGW = RTNCTL_WIDTH - IDW;

    logic [1:0]              r_rstSync;
    logic                    w_rstN;

    arbState_t               r_state;
    logic                    r_flush;
    logic                    r_flushDone;

    logic                    r_rqVld;
    logic [CMD_W-1:0]        r_rqCmd;
    logic [SCMD_W-1:0]       r_rqScmd;
    logic [SIZE_W-1:0]       r_rqSize;
    logic [VADR_W-1:0]       r_rqVadr;
    logic [DATA_W-1:0]       r_rqData;
    logic [RTNCTL_WIDTH-1:0] r_rqRtnctl;

    logic                    w_load;
    logic                    w_flushReq;
    logic                    w_grantEn;
    logic [NUM_REQ-1:0]      w_grant;
    logic [IDW-1:0]          w_grantId;
    logic                    w_anyReq;

    // Reset asserts immediately but releases only on a clock edge, two flops deep.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rstSync <= 2'b00;
        end else begin
            r_rstSync <= {r_rstSync[0], 1'b1};
        end
    end

    assign w_rstN     = r_rstSync[1];
    assign w_load     = !r_rqVld || !bus.mc_rq_stall;
    assign w_flushReq = |bus.flush_req;
    assign w_grantEn  = w_rstN && (r_state == ST_ARB) && !w_flushReq && w_load && w_anyReq;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rrArbiter (
        .clk       (clk),
        .rst_n     (w_rstN),
        .i_req     (bus.req_vld),
        .i_adv     (w_grantEn),
        .o_grant   (w_grant),
        .o_grantId (w_grantId),
        .o_any     (w_anyReq)
    );

    assign bus.req_rdy = w_grantEn ? w_grant : '0;

    // Output register: refills whenever it is empty or its contents leave this cycle.
    always_ff @(posedge clk or negedge w_rstN) begin
        if (!w_rstN) begin
            r_rqVld    <= 1'b0;
            r_rqCmd    <= '0;
            r_rqScmd   <= '0;
            r_rqSize   <= '0;
            r_rqVadr   <= '0;
            r_rqData   <= '0;
            r_rqRtnctl <= '0;
        end else if (w_load) begin
            r_rqVld <= w_grantEn;
            if (w_grantEn) begin
                r_rqCmd    <= bus.req_cmd [w_grantId*CMD_W  +: CMD_W];
                r_rqScmd   <= bus.req_scmd[w_grantId*SCMD_W +: SCMD_W];
                r_rqSize   <= bus.req_size[w_grantId*SIZE_W +: SIZE_W];
                r_rqVadr   <= bus.req_vadr[w_grantId*VADR_W +: VADR_W];
                r_rqData   <= bus.req_data[w_grantId*DATA_W +: DATA_W];
                r_rqRtnctl <= {bus.req_tag[w_grantId*TAGW +: TAGW], w_grantId};
            end
        end
    end

    assign bus.mc_rq_vld    = r_rqVld;
    assign bus.mc_rq_cmd    = r_rqCmd;
    assign bus.mc_rq_scmd   = r_rqScmd;
    assign bus.mc_rq_size   = r_rqSize;
    assign bus.mc_rq_vadr   = r_rqVadr;
    assign bus.mc_rq_data   = r_rqData;
    assign bus.mc_rq_rtnctl = r_rqRtnctl;

    // Flush sequencer: stop granting, let the held request go, issue one flush, await completion.
    always_ff @(posedge clk or negedge w_rstN) begin
        if (!w_rstN) begin
            r_state     <= ST_ARB;
            r_flush     <= 1'b0;
            r_flushDone <= 1'b0;
        end else begin
            r_flushDone <= 1'b0;
            case (r_state)
                ST_ARB: begin
                    if (w_flushReq) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_load) begin
                        r_state <= ST_FLUSH;
                        r_flush <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (!bus.mc_rq_stall) begin
                        r_flush <= 1'b0;
                        r_state <= ST_WAIT_CMPLT;
                    end
                end
                ST_WAIT_CMPLT: begin
                    if (bus.mc_rs_flush_cmplt) begin
                        r_flushDone <= 1'b1;
                        r_state     <= ST_ARB;
                    end
                end
                default: begin
                    r_state <= ST_ARB;
                end
            endcase
        end
    end

    assign bus.mc_rq_flush = r_flush;
    assign bus.flush_done  = r_flushDone;

    // Responses steer straight through to the requester named in the rtnctl id bits.
    always_comb begin
        bus.rsp_vld = '0;
        bus.rsp_vld[bus.mc_rs_rtnctl[IDW-1:0]] = bus.mc_rs_vld;
    end

    assign bus.rsp_cmd     = bus.mc_rs_cmd;
    assign bus.rsp_scmd    = bus.mc_rs_scmd;
    assign bus.rsp_data    = bus.mc_rs_data;
    assign bus.rsp_tag     = bus.mc_rs_rtnctl[RTNCTL_WIDTH-1:IDW];
    assign bus.mc_rs_stall = |bus.rsp_stall;

endmodule

// File: tb/tb_mc_port_arbiter.sv
// Directed bench for mc_port_arbiter: round-robin order, stall hold,
// response routing, flush sequence and reset in the middle of a flush.
module tb_mc_port_arbiter;

    localparam int NUM_REQ      = 4;
    localparam int RTNCTL_WIDTH = 32;
    localparam int TAGW         = 30;

    logic clk = 1'b0;
    logic i_reset_n;

    int checkCount = 0;
    int passCount  = 0;

    mc_port_arbiter_if #(.NUM_REQ(NUM_REQ), .RTNCTL_WIDTH(RTNCTL_WIDTH)) bus ();

    mc_port_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .RTNCTL_WIDTH (RTNCTL_WIDTH)
    ) dut (
        .clk       (clk),
        .i_reset_n (i_reset_n),
        .bus       (bus)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Hard stop in case something hangs.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] expRtnctl(input int id, input logic [TAGW-1:0] tag);
        return {tag, 2'(id)};
    endfunction

    task automatic applyStimulus(input int id, input logic [47:0] vadr, input logic [TAGW-1:0] tag);
        bus.req_cmd [id*3  +: 3]  = 3'(id + 1);
        bus.req_scmd[id*4  +: 4]  = 4'(id + 8);
        bus.req_size[id*2  +: 2]  = 2'(id);
        bus.req_vadr[id*48 +: 48] = vadr;
        bus.req_data[id*64 +: 64] = 64'hD00D_0000_0000_0000 | 64'(id);
        bus.req_tag [id*TAGW +: TAGW] = tag;
    endtask

    // Main directed sequence.
    initial begin
        i_reset_n             = 1'b0;
        bus.req_vld           = '0;
        bus.mc_rq_stall       = 1'b0;
        bus.mc_rs_vld         = 1'b0;
        bus.mc_rs_cmd         = '0;
        bus.mc_rs_scmd        = '0;
        bus.mc_rs_data        = '0;
        bus.mc_rs_rtnctl      = '0;
        bus.rsp_stall         = '0;
        bus.flush_req         = '0;
        bus.mc_rs_flush_cmplt = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            applyStimulus(i, 48'h1234_0000_0000 | 48'(i * 'h100), TAGW'(16 + i));
        end

        #3;
        checkOutput("resetRqVld", 64'(bus.mc_rq_vld), 64'd0);
        checkOutput("resetRtnctl", 64'(bus.mc_rq_rtnctl), 64'd0);
        checkOutput("resetFlush", 64'(bus.mc_rq_flush), 64'd0);
        checkOutput("resetFlushDone", 64'(bus.flush_done), 64'd0);
        bus.req_vld = 4'hF;
        #1;
        checkOutput("rdyInReset", 64'(bus.req_rdy), 64'd0);

        tick();
        tick();
        i_reset_n = 1'b1;
        tick();
        checkOutput("rdyWhileSyncing", 64'(bus.req_rdy), 64'd0);
        tick();

        for (int n = 0; n < 5; n++) begin
            int id;
            id = n % NUM_REQ;
            checkOutput($sformatf("rrRdy%0d", n), 64'(bus.req_rdy), 64'(1 << id));
            tick();
            checkOutput($sformatf("rrVld%0d", n), 64'(bus.mc_rq_vld), 64'd1);
            checkOutput($sformatf("rrRtnctl%0d", n), 64'(bus.mc_rq_rtnctl), 64'(expRtnctl(id, TAGW'(16 + id))));
            checkOutput($sformatf("rrVadr%0d", n), 64'(bus.mc_rq_vadr), 64'(48'h1234_0000_0000 | 48'(id * 'h100)));
            checkOutput($sformatf("rrCmd%0d", n), 64'(bus.mc_rq_cmd), 64'(id + 1));
        end
        bus.req_vld = '0;
        tick();
        checkOutput("rrIdle", 64'(bus.mc_rq_vld), 64'd0);

        applyStimulus(2, 48'h1000, TAGW'(18));
        bus.mc_rq_stall = 1'b1;
        bus.req_vld     = 4'b0100;
        #1;
        checkOutput("stallGrant2", 64'(bus.req_rdy), 64'b0100);
        tick();
        bus.req_vld = 4'b1011;
        for (int k = 0; k < 5; k++) begin
            #1;
            checkOutput($sformatf("stallVld%0d", k), 64'(bus.mc_rq_vld), 64'd1);
            checkOutput($sformatf("stallVadr%0d", k), 64'(bus.mc_rq_vadr), 64'h1000);
            checkOutput($sformatf("stallRdy%0d", k), 64'(bus.req_rdy), 64'd0);
            if (k < 4) tick();
        end
        bus.mc_rq_stall = 1'b0;
        #1;
        checkOutput("xferRdy3", 64'(bus.req_rdy), 64'b1000);
        checkOutput("xferVadr", 64'(bus.mc_rq_vadr), 64'h1000);
        tick();
        checkOutput("afterXferRtnctl", 64'(bus.mc_rq_rtnctl), 64'(expRtnctl(3, TAGW'(19))));
        bus.req_vld = '0;
        tick();
        checkOutput("afterXferIdle", 64'(bus.mc_rq_vld), 64'd0);

        bus.mc_rs_vld    = 1'b1;
        bus.mc_rs_rtnctl = {30'h5A, 2'd3};
        bus.mc_rs_data   = 64'hCAFE_F00D;
        bus.mc_rs_cmd    = 3'd5;
        bus.mc_rs_scmd   = 4'd9;
        #1;
        checkOutput("rspVld3", 64'(bus.rsp_vld), 64'b1000);
        checkOutput("rspTag", 64'(bus.rsp_tag), 64'h5A);
        checkOutput("rspData", bus.rsp_data, 64'hCAFE_F00D);
        checkOutput("rspCmd", 64'(bus.rsp_cmd), 64'd5);
        checkOutput("rspScmd", 64'(bus.rsp_scmd), 64'd9);
        checkOutput("rsStallIdle", 64'(bus.mc_rs_stall), 64'd0);
        bus.rsp_stall = 4'b0010;
        #1;
        checkOutput("rsStall1", 64'(bus.mc_rs_stall), 64'd1);
        bus.mc_rs_rtnctl = {30'h3, 2'd0};
        #1;
        checkOutput("rspVld0", 64'(bus.rsp_vld), 64'b0001);
        checkOutput("rspTag3", 64'(bus.rsp_tag), 64'h3);
        bus.mc_rs_vld = 1'b0;
        bus.rsp_stall = '0;
        #1;
        checkOutput("rspVldOff", 64'(bus.rsp_vld), 64'd0);

        bus.mc_rs_flush_cmplt = 1'b1;
        tick();
        bus.mc_rs_flush_cmplt = 1'b0;
        checkOutput("strayCmpltDone", 64'(bus.flush_done), 64'd0);
        tick();
        checkOutput("strayCmpltDone2", 64'(bus.flush_done), 64'd0);

        bus.mc_rq_stall = 1'b1;
        bus.req_vld     = 4'b0001;
        #1;
        checkOutput("flushPreGrant0", 64'(bus.req_rdy), 64'b0001);
        tick();
        bus.req_vld   = 4'b1000;
        bus.flush_req = 4'b0010;
        #1;
        checkOutput("flushPriority", 64'(bus.req_rdy), 64'd0);
        tick();
        bus.flush_req = '0;
        #1;
        checkOutput("drainRdy", 64'(bus.req_rdy), 64'd0);
        checkOutput("drainHeldVld", 64'(bus.mc_rq_vld), 64'd1);
        checkOutput("drainNoFlush", 64'(bus.mc_rq_flush), 64'd0);
        tick();
        checkOutput("drainStillHeld", 64'(bus.mc_rq_vld), 64'd1);
        checkOutput("drainStillNoFlush", 64'(bus.mc_rq_flush), 64'd0);
        bus.mc_rq_stall = 1'b0;
        #1;
        checkOutput("drainXferRdy", 64'(bus.req_rdy), 64'd0);
        tick();
        checkOutput("flushPulse", 64'(bus.mc_rq_flush), 64'd1);
        checkOutput("flushRqEmpty", 64'(bus.mc_rq_vld), 64'd0);
        bus.mc_rq_stall = 1'b1;
        tick();
        checkOutput("flushHeldStall", 64'(bus.mc_rq_flush), 64'd1);
        bus.mc_rq_stall = 1'b0;
        tick();
        checkOutput("flushDropped", 64'(bus.mc_rq_flush), 64'd0);
        checkOutput("waitNoDone", 64'(bus.flush_done), 64'd0);
        checkOutput("waitRdy", 64'(bus.req_rdy), 64'd0);
        tick();
        checkOutput("waitNoDone2", 64'(bus.flush_done), 64'd0);
        checkOutput("waitNoFlush", 64'(bus.mc_rq_flush), 64'd0);
        bus.mc_rs_flush_cmplt = 1'b1;
        tick();
        bus.mc_rs_flush_cmplt = 1'b0;
        checkOutput("flushDone", 64'(bus.flush_done), 64'd1);
        checkOutput("backToArbRdy", 64'(bus.req_rdy), 64'b1000);
        tick();
        checkOutput("flushDoneOnce", 64'(bus.flush_done), 64'd0);
        checkOutput("postFlushRtnctl", 64'(bus.mc_rq_rtnctl), 64'(expRtnctl(3, TAGW'(19))));
        bus.req_vld = '0;
        tick();

        bus.mc_rq_stall = 1'b1;
        bus.req_vld     = 4'b0001;
        tick();
        bus.req_vld   = '0;
        bus.flush_req = 4'b0001;
        tick();
        bus.flush_req   = '0;
        bus.mc_rq_stall = 1'b0;
        tick();
        tick();
        checkOutput("preResetVadr", 64'(bus.mc_rq_vadr), 64'h1234_0000_0000);
        bus.mc_rs_flush_cmplt = 1'b1;
        #2;
        i_reset_n = 1'b0;
        #1;
        checkOutput("asyncRqVld", 64'(bus.mc_rq_vld), 64'd0);
        checkOutput("asyncVadr", 64'(bus.mc_rq_vadr), 64'd0);
        checkOutput("asyncRtnctl", 64'(bus.mc_rq_rtnctl), 64'd0);
        checkOutput("asyncFlush", 64'(bus.mc_rq_flush), 64'd0);
        checkOutput("asyncDone", 64'(bus.flush_done), 64'd0);
        tick();
        tick();
        bus.mc_rs_flush_cmplt = 1'b0;
        bus.req_vld           = 4'hF;
        i_reset_n             = 1'b1;
        tick();
        checkOutput("relNoDone", 64'(bus.flush_done), 64'd0);
        checkOutput("relRdySync", 64'(bus.req_rdy), 64'd0);
        tick();
        checkOutput("relNoDone2", 64'(bus.flush_done), 64'd0);
        checkOutput("relFirstRdy", 64'(bus.req_rdy), 64'b0001);
        tick();
        checkOutput("relFirstVld", 64'(bus.mc_rq_vld), 64'd1);
        checkOutput("relFirstRtnctl", 64'(bus.mc_rq_rtnctl), 64'(expRtnctl(0, TAGW'(16))));
        checkOutput("relNoDone3", 64'(bus.flush_done), 64'd0);
        bus.req_vld = '0;
        tick();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
